btb_update_queue: RTL and testbench
===================================

# btb_update_queue

Buffers BTB training requests from the backend and issues them one per cycle to the BTB update port (`update`, `updateInfo.start_addr`, `updateInfo.btbEntry`). It sits directly upstream of the BTB write side. Bursts of resolved branches are absorbed without back-pressure on commit. Repeated updates to the same fetch block are coalesced so that the BTB is written only with the newest entry.

## Interface
- `DEPTH`, default 4: queue entries; must be a power of two, at least 2.
- `CNT_W`, default 16: width of the drop counter.
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `upd_valid` in 1: a training request is presented this cycle.
- `upd_start_addr` in `VADDR_SIZE`: fetch-block start address of the request.
- `upd_entry` in `$bits(BTBEntry)`: entry to write; requests with `en`=0 are discarded.
- `wr_block` in 1: the BTB write port is unavailable this cycle; hold the head entry.
- `btb_update` out 1: write strobe to the BTB.
- `btb_start_addr` out `VADDR_SIZE`: address of the head entry.
- `btb_entry` out `$bits(BTBEntry)`: data of the head entry.
- `full` out 1: count equals `DEPTH`.
- `drop_cnt` out `CNT_W`: saturating count of dropped requests.

## Operation
- Storage is a circular FIFO: per-entry valid, addr and entry; head and tail pointers of `$clog2(DEPTH)` bits that wrap naturally; count of `$clog2(DEPTH)+1` bits.
- **Issue:** `btb_update = head_valid & ~wr_block`. When it is asserted, the head is popped at the clock edge. `btb_start_addr` and `btb_entry` always show the head slot; their value is don't-care when the queue is empty.
- **Input filter:**
  - A request with `upd_valid`=1 and `upd_entry.en`=0 is ignored.
  - It does not count as a drop.
- **Coalescing:**
  - The incoming `upd_start_addr` is compared against every valid slot.
  - The slot being popped this cycle is excluded from the comparison.
  - On a hit, that slot's entry is overwritten in place with `upd_entry`; the pointers and count are unchanged.
  - At most one hit is possible, because the queue never holds duplicates.
- **Enqueue:**
  - A request with no hit is written at the tail when `count < DEPTH` or a pop happens in the same cycle.
  - The tail and count are then updated.
- **Drop:**
  - A request with no hit that arrives while the queue is full and nothing is popped is discarded.
  - `drop_cnt` increments and saturates at all-ones.
- Count update: +1 on enqueue only, -1 on pop only, unchanged when both or neither occur.

## Timing
- Reset values:
  - all valid bits 0, head = tail = 0, count 0;
  - `btb_update` 0, `full` 0, `drop_cnt` 0.
- Reset asserted mid-operation discards all pending entries immediately. It acts asynchronously, and `btb_update` falls without waiting for a clock edge.
- Latency: a request accepted at edge N is at the earliest visible as `btb_update` in cycle N+1, then written by the BTB at edge N+1. There is no same-cycle bypass.
- A coalesce into the head slot in the cycle before its issue is honoured: the new data is issued.
- Simultaneous pop and enqueue when full:
  - the request is accepted;
  - count stays at `DEPTH` and `full` stays 1.
- Simultaneous pop of slot X and a request matching X:
  - there is no coalesce;
  - the request is enqueued as a new entry, so the BTB is written twice and the newer data wins.
- `wr_block` may be held for any number of cycles. During that time requests keep coalescing and enqueuing up to `DEPTH`.
- Throughput: one issue per cycle and one request per cycle.

## Structure
- Shared package (frontend defines) gets `BtbUpdReq`, a packed struct {`start_addr`, `entry`: `BTBEntry`}. It is reused by the backend training path.
- One sub-module, `btb_upd_match`:
  - inputs: the `DEPTH`-wide valid vector, the stored addresses, the incoming address and a pop mask;
  - outputs: a one-hot hit vector and a hit flag.
- Everything else, i.e. the pointers, count, drop counter and storage write logic, stays in `btb_update_queue`.

## Test plan
- **Basic flow:** `upd_valid` with addr 0x1000 and `en`=1, `wr_block`=0 -> next cycle `btb_update`=1 with addr 0x1000; the cycle after, `btb_update`=0.
- **Filter:** a request with `en`=0 -> no `btb_update` ever and `drop_cnt` stays 0.
- **Coalescing:**
  - setup: `wr_block`=1; send 0x1000/A, 0x2000/B, then 0x1000/C;
  - expected: count=2;
  - release `wr_block` -> issues are 0x1000/C then 0x2000/B.
- **Overflow:**
  - setup: `wr_block`=1, DEPTH=4; send 6 distinct addresses;
  - expected: `full`=1 after 4 requests and `drop_cnt`=2;
  - release -> the first 4 issue in order and `full` drops after the first pop.
- **Full with pop:** full queue, `wr_block`=0, new request 0x5000 in the same cycle -> accepted, count stays 4, and 0x5000 issues fifth.
- **Reset mid-burst:** 3 entries queued; pulse `rst` between edges -> `btb_update` falls immediately and count=0; after release there are no issues until new requests arrive.

Source files
------------

// File: rtl/btb_update_queue_pkg.sv
// Frontend types shared by the BTB update queue
// and the backend training path.
package btb_update_queue_pkg;

  localparam int VADDR_SIZE = 39;

  typedef struct packed {
    logic                  en;
    logic                  is_rvc;
    logic [1:0]            br_type;
    logic [VADDR_SIZE-1:0] target;
  } BTBEntry;

  typedef struct packed {
    logic [VADDR_SIZE-1:0] start_addr;
    BTBEntry               entry;
  } BtbUpdReq;

endpackage

// File: rtl/btb_update_queue_if.sv
// Training request / BTB write bundle of the
// BTB update queue.
interface btb_update_queue_if #(
  parameter int CNT_W = 16
);
  import btb_update_queue_pkg::*;

  logic                  upd_valid;
  logic [VADDR_SIZE-1:0] upd_start_addr;
  BTBEntry               upd_entry;
  logic                  wr_block;
  logic                  btb_update;
  logic [VADDR_SIZE-1:0] btb_start_addr;
  BTBEntry               btb_entry;
  logic                  full;
  logic [CNT_W-1:0]      drop_cnt;

  modport master (
    output upd_valid, upd_start_addr, upd_entry,
    output wr_block,
    input  btb_update, btb_start_addr, btb_entry,
    input  full, drop_cnt
  );

  modport slave (
    input  upd_valid, upd_start_addr, upd_entry,
    input  wr_block,
    output btb_update, btb_start_addr, btb_entry,
    output full, drop_cnt
  );

endinterface

// File: rtl/btb_update_queue_match.sv
// Address match of an incoming request against the
// queued slots, excluding the slot being popped.
module btb_upd_match
  import btb_update_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]      valid,
  input  logic [VADDR_SIZE-1:0] addrs [DEPTH],
  input  logic [VADDR_SIZE-1:0] addr,
  input  logic [DEPTH-1:0]      pop_mask,
  output logic [DEPTH-1:0]      hit,
  output logic                  hit_any
);

  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit[i] = valid[i] & ~pop_mask[i] &
               (addrs[i] == addr);
    end
  end

  assign hit_any = |hit;

endmodule

// File: rtl/btb_update_queue.sv
// Coalescing FIFO of BTB training requests, issuing
// one BTB write per cycle from the head slot.
module btb_update_queue
  import btb_update_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  btb_update_queue_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DEPTH-1:0]      valid;
  BtbUpdReq              slot [DEPTH];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [CW-1:0]         count;
  logic [CNT_W-1:0]      drops;

  logic                  head_valid;
  logic                  pop;
  logic                  req;
  logic                  enq;
  logic                  drop;
  logic                  hit_any;
  logic [DEPTH-1:0]      hit;
  logic [DEPTH-1:0]      pop_mask;
  logic [VADDR_SIZE-1:0] addrs [DEPTH];
  BtbUpdReq              req_in;

  assign head_valid = valid[head];
  assign pop  = head_valid & ~bus.wr_block;
  assign req  = bus.upd_valid & bus.upd_entry.en;
  assign enq  = req & ~hit_any &
                ((count != FULL_CNT) | pop);
  assign drop = req & ~hit_any & ~enq;

  assign req_in.start_addr = bus.upd_start_addr;
  assign req_in.entry      = bus.upd_entry;

  always_comb begin
    pop_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pop_mask[i] = pop & (head == PW'(i));
      addrs[i]    = slot[i].start_addr;
    end
  end

  btb_upd_match #(
    .DEPTH (DEPTH)
  ) u_match (
    .valid    (valid),
    .addrs    (addrs),
    .addr     (bus.upd_start_addr),
    .pop_mask (pop_mask),
    .hit      (hit),
    .hit_any  (hit_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      drops <= '0;
    end else begin
      // a full-queue pop frees the slot the enqueue reuses
      for (int i = 0; i < DEPTH; i++) begin
        if (pop_mask[i])
          valid[i] <= 1'b0;
        if (enq && tail == PW'(i))
          valid[i] <= 1'b1;
      end
      if (pop)
        head <= head + PW'(1);
      if (enq)
        tail <= tail + PW'(1);
      unique case ({enq, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop && drops != '1)
        drops <= drops + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (enq && tail == PW'(i))
        slot[i] <= req_in;
      else if (req && hit[i])
        slot[i].entry <= bus.upd_entry;
    end
  end

  assign bus.btb_update     = pop;
  assign bus.btb_start_addr = slot[head].start_addr;
  assign bus.btb_entry      = slot[head].entry;
  assign bus.full           = (count == FULL_CNT);
  assign bus.drop_cnt       = drops;

endmodule

// File: tb/tb_btb_update_queue.sv
// Directed bench for btb_update_queue.
module tb_btb_update_queue;
  import btb_update_queue_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  btb_update_queue_if #(.CNT_W(16)) bus ();

  btb_update_queue #(
    .DEPTH (4),
    .CNT_W (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic BTBEntry mk(
    input logic en,
    input logic [VADDR_SIZE-1:0] t
  );
    BTBEntry e;
    e.en      = en;
    e.is_rvc  = 1'b0;
    e.br_type = 2'b01;
    e.target  = t;
    return e;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic send(
    input logic [VADDR_SIZE-1:0] a,
    input BTBEntry e
  );
    bus.upd_valid      = 1'b1;
    bus.upd_start_addr = a;
    bus.upd_entry      = e;
  endtask

  task automatic idle();
    bus.upd_valid      = 1'b0;
    bus.upd_start_addr = '0;
    bus.upd_entry      = '0;
  endtask

  task automatic issue(
    input string tag,
    input logic [VADDR_SIZE-1:0] a,
    input BTBEntry e
  );
    chk({tag, "_upd"}, 64'(bus.btb_update), 64'(1));
    chk({tag, "_addr"}, 64'(bus.btb_start_addr), 64'(a));
    chk({tag, "_ent"}, 64'(bus.btb_entry), 64'(e));
  endtask

  initial begin
    idle();
    bus.wr_block = 1'b0;
    nxt();
    nxt();
    #1;
    chk("rst_upd", 64'(bus.btb_update), 64'(0));
    chk("rst_full", 64'(bus.full), 64'(0));
    chk("rst_drop", 64'(bus.drop_cnt), 64'(0));
    chk("rst_cnt", 64'(dut.count), 64'(0));
    rst = 1'b0;

    // basic flow, no same-cycle bypass
    nxt();
    send(39'h1000, mk(1'b1, 39'hA));
    #1;
    chk("bas_nobyp", 64'(bus.btb_update), 64'(0));
    nxt();
    idle();
    #1;
    issue("bas", 39'h1000, mk(1'b1, 39'hA));
    nxt();
    #1;
    chk("bas_done", 64'(bus.btb_update), 64'(0));

    // en=0 filter
    nxt();
    send(39'h3000, mk(1'b0, 39'hF));
    nxt();
    idle();
    #1;
    chk("flt_upd0", 64'(bus.btb_update), 64'(0));
    nxt();
    #1;
    chk("flt_upd1", 64'(bus.btb_update), 64'(0));
    chk("flt_drop", 64'(bus.drop_cnt), 64'(0));

    // coalescing under wr_block
    bus.wr_block = 1'b1;
    send(39'h1000, mk(1'b1, 39'hA));
    nxt();
    send(39'h2000, mk(1'b1, 39'hB));
    nxt();
    send(39'h1000, mk(1'b1, 39'hC));
    nxt();
    idle();
    #1;
    chk("coa_cnt", 64'(dut.count), 64'(2));
    chk("coa_blk", 64'(bus.btb_update), 64'(0));
    bus.wr_block = 1'b0;
    #1;
    issue("coa1", 39'h1000, mk(1'b1, 39'hC));
    nxt();
    #1;
    issue("coa2", 39'h2000, mk(1'b1, 39'hB));
    nxt();
    #1;
    chk("coa_done", 64'(bus.btb_update), 64'(0));

    // overflow: six distinct requests into four slots
    bus.wr_block = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      send(39'(i * 'h1000), mk(1'b1, 39'(i)));
      if (i == 5) begin
        #1;
        chk("ovf_full", 64'(bus.full), 64'(1));
      end
      nxt();
    end
    idle();
    #1;
    chk("ovf_drop", 64'(bus.drop_cnt), 64'(2));
    bus.wr_block = 1'b0;
    #1;
    issue("ovf1", 39'h1000, mk(1'b1, 39'd1));
    nxt();
    #1;
    chk("ovf_nfull", 64'(bus.full), 64'(0));
    issue("ovf2", 39'h2000, mk(1'b1, 39'd2));
    nxt();
    #1;
    issue("ovf3", 39'h3000, mk(1'b1, 39'd3));
    nxt();
    #1;
    issue("ovf4", 39'h4000, mk(1'b1, 39'd4));
    nxt();
    #1;
    chk("ovf_done", 64'(bus.btb_update), 64'(0));

    // full queue with simultaneous pop and enqueue
    bus.wr_block = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      send(39'(i * 'h1000), mk(1'b1, 39'(i + 16)));
      nxt();
    end
    bus.wr_block = 1'b0;
    send(39'h5000, mk(1'b1, 39'h55));
    #1;
    chk("fp_full0", 64'(bus.full), 64'(1));
    issue("fp1", 39'h1000, mk(1'b1, 39'd17));
    nxt();
    idle();
    #1;
    chk("fp_cnt", 64'(dut.count), 64'(4));
    chk("fp_full1", 64'(bus.full), 64'(1));
    issue("fp2", 39'h2000, mk(1'b1, 39'd18));
    nxt();
    #1;
    issue("fp3", 39'h3000, mk(1'b1, 39'd19));
    nxt();
    #1;
    issue("fp4", 39'h4000, mk(1'b1, 39'd20));
    nxt();
    #1;
    issue("fp5", 39'h5000, mk(1'b1, 39'h55));
    chk("fp_drop", 64'(bus.drop_cnt), 64'(2));
    nxt();
    #1;
    chk("fp_done", 64'(bus.btb_update), 64'(0));

    // request matching the slot popped this cycle
    bus.wr_block = 1'b1;
    send(39'h7000, mk(1'b1, 39'h70));
    nxt();
    bus.wr_block = 1'b0;
    send(39'h7000, mk(1'b1, 39'h71));
    #1;
    issue("pm1", 39'h7000, mk(1'b1, 39'h70));
    nxt();
    idle();
    #1;
    issue("pm2", 39'h7000, mk(1'b1, 39'h71));
    nxt();
    #1;
    chk("pm_done", 64'(bus.btb_update), 64'(0));

    // asynchronous reset mid-burst
    bus.wr_block = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      send(39'(i * 'h1000), mk(1'b1, 39'(i + 32)));
      nxt();
    end
    idle();
    bus.wr_block = 1'b0;
    #1;
    chk("ar_pre", 64'(bus.btb_update), 64'(1));
    #1;
    rst = 1'b1;
    #1;
    chk("ar_upd", 64'(bus.btb_update), 64'(0));
    chk("ar_cnt", 64'(dut.count), 64'(0));
    chk("ar_drop", 64'(bus.drop_cnt), 64'(0));
    #1;
    rst = 1'b0;
    nxt();
    #1;
    chk("ar_idle0", 64'(bus.btb_update), 64'(0));
    nxt();
    #1;
    chk("ar_idle1", 64'(bus.btb_update), 64'(0));
    send(39'h8000, mk(1'b1, 39'h80));
    nxt();
    idle();
    #1;
    issue("ar_new", 39'h8000, mk(1'b1, 39'h80));
    nxt();
    #1;
    chk("ar_done", 64'(bus.btb_update), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
